// File: rtl/accumulate_stream_pkg.sv
// Shared definitions for the accumulate_stream block: FSM state encoding
// and default sizing constants.
package acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int DEF_W         = 4;
    localparam int DEF_MAX_BEATS = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/accumulate_stream_if.sv
// Operand stream in, frame result out. The master side is the producer and
// result consumer; the slave side is the accumulator itself.
interface accumulate_stream_if
    import acc_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    localparam int CW       = $clog2(MAX_BEATS + 1)
);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_overflow;
    logic [CW-1:0] out_count;
    logic          out_trunc;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_overflow,
               out_count, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_overflow,
               out_count, out_trunc
    );

endinterface

// File: rtl/accumulate_stream_adder.sv
// The team's combinational n-bit adder. Its overflow output only catches the
// negative+negative case, so callers needing full signed overflow compute it
// themselves.
module arithmetic_operators #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    logic [n:0] wide_sum;

    // Full-width add; the extra bit is the unsigned carry out.
    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
    end

    assign sum      = wide_sum[n-1:0];
    assign cout     = wide_sum[n];
    assign overflow = a[n-1] & b[n-1] & ~wide_sum[n-1];

endmodule

// File: rtl/accumulate_stream.sv
// Frame accumulator: sums a stream of operands, tracks sticky carry and
// signed overflow, and presents one registered result per frame.
module accumulate_stream
    import acc_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    accumulate_stream_if.slave  bus
);

    state_t        state, state_n;
    logic [W-1:0]  acc, acc_n;
    logic          cout_s, cout_n;
    logic          ovf_s, ovf_n;
    logic [CW-1:0] count, count_n;
    logic          trunc, trunc_n;

    logic [W-1:0]  base;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          add_ovf_unused;
    logic          add_ovf;
    logic          accept;
    logic [CW-1:0] beat_count;
    logic          cap_hit;

    // A new frame starts from zero rather than whatever acc holds.
    assign base       = (state == IDLE) ? '0 : acc;
    assign accept     = bus.in_valid && (state != HOLD);
    assign beat_count = (state == IDLE) ? CW'(1) : count + CW'(1);
    assign cap_hit    = (beat_count == CW'(MAX_BEATS));

    arithmetic_operators #(.n(W)) u_adder (
        .a        (base),
        .b        (bus.in_data),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf_unused)
    );

    // Signed overflow covers both same-sign cases, unlike the adder's flag.
    assign add_ovf = (base[W-1] == bus.in_data[W-1]) && (add_sum[W-1] != base[W-1]);

    // Next-state and next-datapath decode.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cout_n  = cout_s;
        ovf_n   = ovf_s;
        count_n = count;
        trunc_n = trunc;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_n   = add_sum;
                    count_n = beat_count;
                    cout_n  = ((state == ACCUM) && cout_s) || add_cout;
                    ovf_n   = ((state == ACCUM) && ovf_s) || add_ovf;
                    trunc_n = 1'b0;
                    if (bus.in_last || cap_hit) begin
                        state_n = HOLD;
                        trunc_n = !bus.in_last;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                    acc_n   = '0;
                    cout_n  = 1'b0;
                    ovf_n   = 1'b0;
                    count_n = '0;
                    trunc_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cout_s <= 1'b0;
            ovf_s  <= 1'b0;
            count  <= '0;
            trunc  <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cout_s <= cout_n;
            ovf_s  <= ovf_n;
            count  <= count_n;
            trunc  <= trunc_n;
        end
    end

    assign bus.in_ready     = (state != HOLD);
    assign bus.out_valid    = (state == HOLD);
    assign bus.out_sum      = acc;
    assign bus.out_cout     = cout_s;
    assign bus.out_overflow = ovf_s;
    assign bus.out_count    = count;
    assign bus.out_trunc    = trunc;

endmodule
